// File: rtl/dmem_responder.sv
// Fixed-latency word memory behind the cache D-port: accept -> ACK after LATENCY edges, then one idle edge.
// Backpressure: the initiator holds CSN until ACK; no new accept while BUSY, so throughput is 1 per LATENCY+2.
module dmem_responder #(
    parameter int LATENCY     = 1,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_MEM_CSN,
    input  logic [11:0] D_MEM_ADDR,
    input  logic        D_MEM_WEN,
    input  logic [3:0]  D_MEM_BE,
    input  logic [31:0] D_MEM_DI,
    output logic [31:0] D_MEM_DOUT,
    output logic        D_MEM_ACK,
    output logic        D_MEM_BUSY,
    output logic        D_MEM_ERR,
    output logic [15:0] RD_CNT,
    output logic [15:0] WR_CNT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [11:0]   addr_q;
    logic          wen_q;
    logic [3:0]    be_q;
    logic [31:0]   di_q;
    logic [31:0]   dout_q;
    logic          oor_q;
    logic [15:0]   rd_cnt_q, wr_cnt_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept, do_access, in_range;
    logic [AW-1:0] idx;

    assign accept    = (state_q == S_IDLE) && !D_MEM_CSN;
    assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign in_range  = 32'(addr_q) < 32'(DEPTH_WORDS);
    assign idx       = addr_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (!D_MEM_CSN) begin
                state_d = S_WAIT;
                cnt_d   = LAT_M1;
            end
            S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
                    else               cnt_d   = cnt_q - 4'd1;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Array writes share the reset branch so a reset landing on the commit edge suppresses the write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 12'd0;
            wen_q    <= 1'b0;
            be_q     <= 4'd0;
            di_q     <= 32'd0;
            dout_q   <= 32'd0;
            oor_q    <= 1'b0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= D_MEM_ADDR;
                wen_q  <= D_MEM_WEN;
                be_q   <= D_MEM_BE;
                di_q   <= D_MEM_DI;
            end
            if (do_access) begin
                oor_q <= !in_range;
                if (wen_q) begin
                    if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
                    if (in_range) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be_q[b]) mem[idx][8*b +: 8] <= di_q[8*b +: 8];
                        end
                    end
                end else begin
                    if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
                    dout_q <= in_range ? mem[idx] : 32'd0;
                end
            end
        end
    end

    assign D_MEM_DOUT = dout_q;
    assign D_MEM_ACK  = (state_q == S_RESP);
    assign D_MEM_BUSY = (state_q != S_IDLE);
    assign D_MEM_ERR  = (state_q == S_RESP) && oor_q;
    assign RD_CNT     = rd_cnt_q;
    assign WR_CNT     = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 1, 4 and 8 sharing one clock.
module tb_dmem_responder;

    typedef struct {
        int          k;
        logic        wen;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] di;
        logic [31:0] exp_dout;
        logic        exp_err;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic        csn  [3];
    logic [11:0] addr [3];
    logic        wen  [3];
    logic [3:0]  be   [3];
    logic [31:0] di   [3];
    logic [31:0] dout [3];
    logic        ack  [3];
    logic        busy [3];
    logic        err  [3];
    logic [15:0] rdc  [3];
    logic [15:0] wrc  [3];

    int n_chk  = 0;
    int n_pass = 0;
    int lat_of [3] = '{1, 4, 8};
    vec_t tbl [19];

    dmem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut_a (
        .CLK(clk), .RST(rst[0]), .D_MEM_CSN(csn[0]), .D_MEM_ADDR(addr[0]), .D_MEM_WEN(wen[0]),
        .D_MEM_BE(be[0]), .D_MEM_DI(di[0]), .D_MEM_DOUT(dout[0]), .D_MEM_ACK(ack[0]),
        .D_MEM_BUSY(busy[0]), .D_MEM_ERR(err[0]), .RD_CNT(rdc[0]), .WR_CNT(wrc[0]));

    dmem_responder #(.LATENCY(4), .DEPTH_WORDS(1024)) dut_b (
        .CLK(clk), .RST(rst[1]), .D_MEM_CSN(csn[1]), .D_MEM_ADDR(addr[1]), .D_MEM_WEN(wen[1]),
        .D_MEM_BE(be[1]), .D_MEM_DI(di[1]), .D_MEM_DOUT(dout[1]), .D_MEM_ACK(ack[1]),
        .D_MEM_BUSY(busy[1]), .D_MEM_ERR(err[1]), .RD_CNT(rdc[1]), .WR_CNT(wrc[1]));

    dmem_responder #(.LATENCY(8), .DEPTH_WORDS(1024)) dut_c (
        .CLK(clk), .RST(rst[2]), .D_MEM_CSN(csn[2]), .D_MEM_ADDR(addr[2]), .D_MEM_WEN(wen[2]),
        .D_MEM_BE(be[2]), .D_MEM_DI(di[2]), .D_MEM_DOUT(dout[2]), .D_MEM_ACK(ack[2]),
        .D_MEM_BUSY(busy[2]), .D_MEM_ERR(err[2]), .RD_CNT(rdc[2]), .WR_CNT(wrc[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    // One complete access; inputs are scrambled right after accept to prove they are ignored.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int nb;
        bit got;
        @(negedge clk);
        csn[v.k] = 1'b0; wen[v.k] = v.wen; addr[v.k] = v.addr; be[v.k] = v.be; di[v.k] = v.di;
        @(posedge clk); #1;
        csn[v.k] = 1'b1; wen[v.k] = ~v.wen; addr[v.k] = ~v.addr; be[v.k] = ~v.be; di[v.k] = ~v.di;
        nb  = busy[v.k] ? 1 : 0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy[v.k]) nb++;
            if (ack[v.k]) got = 1'b1;
        end
        chk({tag, " ack_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(lat_of[v.k]));
        chk({tag, " dout"}, dout[v.k], v.exp_dout);
        chk({tag, " err"}, 32'(err[v.k]), 32'(v.exp_err));
        chk({tag, " rd_cnt"}, 32'(rdc[v.k]), 32'(v.exp_rd));
        chk({tag, " wr_cnt"}, 32'(wrc[v.k]), 32'(v.exp_wr));
        @(posedge clk); #1;
        chk({tag, " ack_one_cycle"}, 32'(ack[v.k]), 32'd0);
        chk({tag, " err_after"}, 32'(err[v.k]), 32'd0);
        chk({tag, " busy_after"}, 32'(busy[v.k]), 32'd0);
        chk({tag, " busy_cycles"}, 32'(nb), 32'(lat_of[v.k] + 1));
    endtask

    initial begin
        logic [31:0] burst [4];
        vec_t v;
        int e;
        int prev;
        int acks;
        bit saw_ack;

        tbl = '{
            // LATENCY=1: write/read-back, byte enables, out of range
            '{0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0, 16'd0, 16'd1},
            '{0, 1'b0, 12'h010, 4'hF, 32'h00000000, 32'hDEADBEEF, 1'b0, 16'd1, 16'd1},
            '{0, 1'b1, 12'h005, 4'hF, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0, 16'd1, 16'd2},
            '{0, 1'b1, 12'h005, 4'h5, 32'h11223344, 32'hDEADBEEF, 1'b0, 16'd1, 16'd3},
            '{0, 1'b0, 12'h005, 4'h0, 32'h00000000, 32'hAA22CC44, 1'b0, 16'd2, 16'd3},
            '{0, 1'b1, 12'h005, 4'h0, 32'hFFFFFFFF, 32'hAA22CC44, 1'b0, 16'd2, 16'd4},
            '{0, 1'b0, 12'h005, 4'hF, 32'h00000000, 32'hAA22CC44, 1'b0, 16'd3, 16'd4},
            '{0, 1'b0, 12'h400, 4'hF, 32'h00000000, 32'h00000000, 1'b1, 16'd4, 16'd4},
            '{0, 1'b1, 12'h3FF, 4'hF, 32'h5A5A5A5A, 32'h00000000, 1'b0, 16'd4, 16'd5},
            '{0, 1'b1, 12'h7FF, 4'hF, 32'hDEADDEAD, 32'h00000000, 1'b1, 16'd4, 16'd6},
            '{0, 1'b0, 12'h3FF, 4'hF, 32'h00000000, 32'h5A5A5A5A, 1'b0, 16'd5, 16'd6},
            // LATENCY=4: preload refill line, then read it back
            '{1, 1'b1, 12'h020, 4'hF, 32'h11111111, 32'h00000000, 1'b0, 16'd0, 16'd1},
            '{1, 1'b1, 12'h021, 4'hF, 32'h22222222, 32'h00000000, 1'b0, 16'd0, 16'd2},
            '{1, 1'b1, 12'h022, 4'hF, 32'h33333333, 32'h00000000, 1'b0, 16'd0, 16'd3},
            '{1, 1'b1, 12'h023, 4'hF, 32'h44444444, 32'h00000000, 1'b0, 16'd0, 16'd4},
            '{1, 1'b0, 12'h020, 4'hF, 32'h00000000, 32'h11111111, 1'b0, 16'd1, 16'd4},
            '{1, 1'b0, 12'h021, 4'hF, 32'h00000000, 32'h22222222, 1'b0, 16'd2, 16'd4},
            '{1, 1'b0, 12'h022, 4'hF, 32'h00000000, 32'h33333333, 1'b0, 16'd3, 16'd4},
            '{1, 1'b0, 12'h023, 4'hF, 32'h00000000, 32'h44444444, 1'b0, 16'd4, 16'd4}
        };
        burst = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; csn[k] = 1'b1; wen[k] = 1'b0; addr[k] = 12'd0; be[k] = 4'd0; di[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset dout[%0d]", k), dout[k], 32'd0);
            chk($sformatf("reset ack/busy/err[%0d]", k), {29'd0, ack[k], busy[k], err[k]}, 32'd0);
            chk($sformatf("reset counters[%0d]", k), {rdc[k], wrc[k]}, 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Refill burst with CSN held low: ACKs must be LATENCY+2 = 6 edges apart.
        @(negedge clk);
        csn[1] = 1'b0; wen[1] = 1'b0; be[1] = 4'hF; addr[1] = 12'h020;
        e = 0; prev = 0; acks = 0;
        while (acks < 4 && e < 100) begin
            @(posedge clk); #1;
            e++;
            if (ack[1]) begin
                if (acks > 0) chk($sformatf("burst spacing %0d", acks), 32'(e - prev), 32'd6);
                else          chk("burst first ack edge", 32'(e), 32'd5);
                chk($sformatf("burst dout %0d", acks), dout[1], burst[acks]);
                prev = e;
                acks++;
                if (acks == 4) csn[1] = 1'b1;
                else           addr[1] = 12'h020 + 12'(acks);
            end
        end
        chk("burst ack count", 32'(acks), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("burst rd_cnt", 32'(rdc[1]), 32'd8);
        chk("burst busy idle", 32'(busy[1]), 32'd0);

        // Reset in the middle of a LATENCY=8 write: nothing committed, everything cleared.
        v = '{2, 1'b1, 12'h001, 4'hF, 32'h00000000, 32'h00000000, 1'b0, 16'd0, 16'd1};
        run_vec(v, "c_preload");
        @(negedge clk);
        csn[2] = 1'b0; wen[2] = 1'b1; addr[2] = 12'h001; be[2] = 4'hF; di[2] = 32'h12345678;
        @(posedge clk); #1;
        csn[2] = 1'b1;
        chk("c_abort busy before reset", 32'(busy[2]), 32'd1);
        repeat (3) @(posedge clk);
        rst[2] = 1'b1;
        #1;
        chk("c_abort ack", 32'(ack[2]), 32'd0);
        chk("c_abort busy", 32'(busy[2]), 32'd0);
        chk("c_abort counters", {rdc[2], wrc[2]}, 32'd0);
        saw_ack = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack[2] || busy[2]) saw_ack = 1'b1;
        end
        chk("c_abort quiet in reset", 32'(saw_ack), 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        v = '{2, 1'b0, 12'h001, 4'hF, 32'h00000000, 32'h00000000, 1'b0, 16'd1, 16'd0};
        run_vec(v, "c_readback");

        // Counter saturation: jump the read counter near its ceiling, then keep reading.
        force dut_a.rd_cnt_q = 16'hFFFC;
        @(negedge clk);
        release dut_a.rd_cnt_q;
        for (int i = 0; i < 6; i++) begin
            v = '{0, 1'b0, 12'h010, 4'hF, 32'h00000000, 32'hDEADBEEF, 1'b0,
                  (i < 3) ? 16'hFFFD + 16'(i) : 16'hFFFF, 16'd6};
            run_vec(v, $sformatf("sat%0d", i));
        end
        repeat (5) @(posedge clk);
        #1;
        chk("sat stable rd_cnt", 32'(rdc[0]), 32'h0000FFFF);
        chk("sat wr_cnt untouched", 32'(wrc[0]), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
